// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- asynchronous serial receiver, 8N1 (or 8E1), LSB first.
//
// The serial line is brought into the clk domain through a two-flop
// synchroniser. A falling edge seen while idle starts a frame. The start bit
// is confirmed at mid-bit and every later bit is sampled one full bit period
// after the previous sample, so all samples fall near the bit centres.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> 8E1 frame: an even-parity bit follows data bit 7, and a
//                mismatch yields parity_err instead of rx_done.
//   undefined -> 8N1 frame, parity_err tied low.
//
// Parameters:
//   BAUD_RATE  line bit rate
//   CLK_FREQ   clk frequency in Hz (CLKS_PER_BIT = CLK_FREQ / BAUD_RATE)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   rx_in       serial line, idle high, asynchronous to clk
//   data_rx     last correctly received byte
//   rx_done     one-cycle pulse when data_rx is updated
//   frame_err   one-cycle pulse when the stop bit is sampled low
//   parity_err  one-cycle pulse on parity mismatch (parity build only)
//   rx_busy     high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int BAUD_RATE = 9600,
    parameter int CLK_FREQ  = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] data_rx,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    logic             r_sync1;
    logic             r_rx_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data_rx;
    logic             r_rx_done;
    logic             r_frame_err;
    logic             r_busy;

`ifdef UART_RX_PARITY_EN
    logic r_parity_bit;
    logic r_parity_err;
    logic w_parity_bad;

    // Even parity: the data bits and the parity bit together must XOR to 0.
    assign w_parity_bad = ^{r_shift, r_parity_bit};
    assign parity_err   = r_parity_err;
`else
    assign parity_err   = 1'b0;
`endif

    assign data_rx   = r_data_rx;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;
    assign rx_busy   = r_busy;

    // Two-flop synchroniser. Both flops reset to the idle (high) line level
    // so that leaving reset never looks like a start bit.
    // NOTE: every clocked register uses non-blocking assignment so that all
    // flops update together from values sampled before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_rx_s  <= r_sync1;
        end
    end

    // Receive FSM. Status pulses default low every cycle and are raised for
    // a single cycle by the stop-bit sample.
    // NOTE: the byte register data_rx is an output with a defined reset
    // value, so it is reset along with the control state; the shift register
    // is reset too, which keeps the whole block deterministic out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_data_rx   <= 8'h00;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_bit <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_s) begin
                        r_cnt   <= '0;
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                    end
                end

                // Re-check the line at the middle of the start bit; a high
                // level here means the falling edge was only a glitch.
                ST_START: begin
                    if (r_cnt == CNT_HALF_END) begin
                        if (!r_rx_s) begin
                            r_cnt     <= '0;
                            r_bit_idx <= 3'd0;
                            r_state   <= ST_DATA;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                // LSB arrives first, so shift in from the top: after eight
                // shifts the first bit has reached bit 0.
                ST_DATA: begin
                    if (r_cnt == CNT_BIT_END) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (r_cnt == CNT_BIT_END) begin
                        r_cnt        <= '0;
                        r_parity_bit <= r_rx_s;
                        r_state      <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif

                // A good stop bit returns straight to IDLE so a frame that
                // starts right after it is still caught.
                ST_STOP: begin
                    if (r_cnt == CNT_BIT_END) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (w_parity_bad) begin
                                r_parity_err <= 1'b1;
                            end else begin
                                r_data_rx <= r_shift;
                                r_rx_done <= 1'b1;
                            end
`else
                            r_data_rx <= r_shift;
                            r_rx_done <= 1'b1;
`endif
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                // Hold off until the line returns high, so a line stuck low
                // is not decoded as a stream of start bits.
                ST_BREAK: begin
                    if (r_rx_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
//
// The receiver is built with a short bit period (17 clocks, half bit 8) so
// that many frames fit in a short run. Frames are generated bit by bit on
// rx_in; when a frame is launched, the bench works out from the line-level
// frame contents which status pulse it must produce, on which clock edge,
// and which byte it carries. A compare process checks every output on every
// cycle against that expectation, and a few literal values pin the model.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BAUD = 9600;
    localparam int CLKF = 163205;        // 9600*17 + 5: truncates to 17
    localparam int CPB  = CLKF / BAUD;   // clocks per bit
    localparam int HALF = CPB / 2;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR      = 1'b1;
    localparam int STOP_IDX = 10;        // start, 8 data, parity, stop
    localparam int LIT_LAT  = 181;       // 3 + 8 + 10*17
    localparam int LIT_GAP  = 187;       // 11*17
`else
    localparam bit PAR      = 1'b0;
    localparam int STOP_IDX = 9;         // start, 8 data, stop
    localparam int LIT_LAT  = 164;       // 3 + 8 + 9*17
    localparam int LIT_GAP  = 170;       // 10*17
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] data_rx;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    uart_rx #(
        .BAUD_RATE(BAUD),
        .CLK_FREQ (CLKF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .data_rx   (data_rx),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .rx_busy   (rx_busy)
    );

    always #10 clk = ~clk;

    // Rising-edge counter: at the falling edge after edge E, cyc == E.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Expected status events keyed by the edge they follow.
    // kind: 1 = rx_done, 2 = frame_err, 3 = parity_err
    byte unsigned exp_kind[int];
    logic [7:0]   exp_byte[int];
    logic [7:0]   m_data = 8'h00;
    bit           mon_en = 1'b0;

    int n_done  = 0;
    int n_frame = 0;
    int n_par   = 0;
    int last_done_cyc = 0;
    int kind;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle, pulses and data_rx against the model.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            kind = exp_kind.exists(cyc) ? int'(exp_kind[cyc]) : 0;
            if (kind == 1) m_data = exp_byte[cyc];
            check("rx_done",    {31'd0, rx_done},    {31'd0, kind == 1});
            check("frame_err",  {31'd0, frame_err},  {31'd0, kind == 2});
            check("parity_err", {31'd0, parity_err}, {31'd0, kind == 3});
            check("data_rx",    {24'd0, data_rx},    {24'd0, m_data});
            if (rx_done) begin
                n_done++;
                last_done_cyc = cyc;
            end
            if (frame_err)  n_frame++;
            if (parity_err) n_par++;
            if (kind != 0) exp_kind.delete(cyc);
        end
    end

    // Drive idle-high line for n cycles; caller is aligned 1 unit after an edge.
    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send one frame starting now (1 unit after an edge). Leaves rx_in at
    // the stop-bit level and returns aligned at the end of the stop slot.
    task automatic send_frame(input logic [7:0] d, input bit stop_v, input bit flip);
        logic [STOP_IDX:0] fb;
        bit eff_flip;
        int k;
        int e;
        eff_flip = PAR & flip;
        fb = '0;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = d[i];
        if (PAR) fb[9] = (^d) ^ eff_flip;
        fb[STOP_IDX] = stop_v;
        k = cyc;
        // Two synchroniser edges plus the IDLE decision edge, then the
        // mid-bit offset and whole bit periods up to the stop sample.
        e = k + 3 + HALF + STOP_IDX * CPB;
        exp_kind[e] = !stop_v ? 8'd2 : (eff_flip ? 8'd3 : 8'd1);
        exp_byte[e] = d;
        rx_in = fb[0];
        for (int i = 1; i <= STOP_IDX; i++) begin
            repeat (CPB) @(posedge clk);
            #1;
            rx_in = fb[i];
        end
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int d1;
        int nd;
        int nf;
        int np;
        logic [7:0] rd;
        bit st;
        bit fl;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset data_rx",   {24'd0, data_rx}, 32'h00);
        check("reset rx_done",   {31'd0, rx_done}, 32'd0);
        check("reset frame_err", {31'd0, frame_err}, 32'd0);
        check("reset parity",    {31'd0, parity_err}, 32'd0);
        check("reset rx_busy",   {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        idle(CPB);

        // Single 0x55 frame with literal latency.
        k = cyc;
        send_frame(8'h55, 1'b1, 1'b0);
        idle(CPB);
        check("0x55 data",    {24'd0, data_rx}, 32'h55);
        check("0x55 count",   n_done, 1);
        check("0x55 latency", last_done_cyc - k, LIT_LAT);
        check("0x55 busy",    {31'd0, rx_busy}, 32'd0);

        // Back-to-back 0x00 then 0xFF.
        send_frame(8'h00, 1'b1, 1'b0);
        d1 = last_done_cyc;
        check("b2b first data", {24'd0, data_rx}, 32'h00);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(CPB);
        check("b2b second data", {24'd0, data_rx}, 32'hFF);
        check("b2b count",       n_done, 3);
        check("b2b gap",         last_done_cyc - d1, LIT_GAP);

        // Short low glitch: start rejected at mid start bit.
        k = cyc;
        rx_in = 1'b0;
        repeat (HALF / 2) @(posedge clk);
        #1;
        rx_in = 1'b1;
        check("glitch busy during", {31'd0, rx_busy}, 32'd1);
        repeat (3 + HALF - HALF / 2) @(posedge clk);
        #1;
        check("glitch idle by t0+half", {31'd0, rx_busy}, 32'd0);
        idle(2 * CPB);
        check("glitch no pulse", n_done, 3);

        // Stop bit low, line held low, then a good frame.
        send_frame(8'hA5, 1'b0, 1'b0);
        repeat (3 * CPB) @(posedge clk);
        #1;
        check("break busy",     {31'd0, rx_busy}, 32'd1);
        check("break frame_err", n_frame, 1);
        check("break data kept", {24'd0, data_rx}, 32'hFF);
        idle(2 * CPB);
        check("break released", {31'd0, rx_busy}, 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(CPB);
        check("after break data", {24'd0, data_rx}, 32'h3C);
        check("after break count", n_done, 4);

        // Reset during data bit 4 of 0x81.
        nd = n_done;
        fork
            send_frame(8'h81, 1'b1, 1'b0);
            begin
                repeat (5 * CPB + HALF) @(posedge clk);
                #1;
                rst = 1'b1;
                exp_kind.delete();
                m_data = 8'h00;
                #1;
                check("midrst data_rx", {24'd0, data_rx}, 32'h00);
                check("midrst rx_busy", {31'd0, rx_busy}, 32'd0);
                check("midrst pulses",  {29'd0, rx_done, frame_err, parity_err}, 32'd0);
            end
        join
        rst = 1'b0;
        idle(2 * CPB);
        check("postrst idle", {31'd0, rx_busy}, 32'd0);
        check("postrst no pulse", n_done, nd);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(CPB);
        check("postrst data", {24'd0, data_rx}, 32'h81);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the good parity bit is 1.
        np = n_par;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(CPB);
        check("parity good data", {24'd0, data_rx}, 32'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(CPB);
        check("parity bad count", n_par, np + 1);
        check("parity bad data",  {24'd0, data_rx}, 32'h07);
`endif

        // Randomised frames with random gaps, occasional bad stop/parity.
        nf = n_frame;
        for (int it = 0; it < 40; it++) begin
            rd = 8'($urandom);
            st = ($urandom_range(0, 5) != 0);
            fl = ($urandom_range(0, 3) == 0);
            send_frame(rd, st, fl);
            if (!st) begin
                repeat ($urandom_range(0, 2 * CPB)) @(posedge clk);
                #1;
                idle(4 + $urandom_range(0, CPB));
            end else begin
                idle($urandom_range(0, 2 * CPB));
            end
        end
        idle(2 * CPB);
        check("random frame_err seen", {31'd0, n_frame >= nf}, 32'd1);
        check("all events consumed", exp_kind.size(), 0);
        check("final idle", {31'd0, rx_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: the receive-side counterpart of `uart_tx`, using the same 8N1, LSB-first framing.
- Synchronises the `rx_in` line into the `clk` domain and detects the start bit.
- Samples each bit at mid-bit using a clock-per-bit counter.
- Presents each received byte on `data_rx` with a one-cycle `rx_done` strobe.
- Sits between the board RX pin and any byte consumer. Shares the `BAUD_RATE`/`CLK_FREQ` parameter convention with `uart_tx`, so a `uart_tx`→`uart_rx` loopback works out of the box.

## Interface
Parameters:
- `BAUD_RATE`, 9600: line bit rate.
- `CLK_FREQ`, 50000000: `clk` frequency in Hz.
- Derived (localparam): `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE` (integer truncation, 5208 at defaults) and `HALF_BIT = CLKS_PER_BIT / 2` (2604).

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `rx_in` input 1: serial line, idle high, asynchronous to `clk`.
- `data_rx` output 8: last correctly received byte.
- `rx_done` output 1: one-cycle pulse when `data_rx` is updated.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `parity_err` output 1: one-cycle pulse on parity mismatch (see Configuration).
- `rx_busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- `rx_in` passes through a 2-flop synchroniser; the FSM uses only the synchronised value `rx_s`. The synchroniser flops reset to 1.
- The bit counter `cnt` is wide enough for `CLKS_PER_BIT-1`; bit index is 3 bits; the shift register is 8 bits, filled LSB first.
- FSM states:
  - **IDLE**: on `rx_s==0`, clear `cnt` and go to START.
  - **START**: at `cnt==HALF_BIT-1`, sample `rx_s`. If 0, clear `cnt` and bit index, go to DATA. If 1, it was a glitch: return to IDLE with no output pulse.
  - **DATA**: at `cnt==CLKS_PER_BIT-1`, shift `rx_s` in and clear `cnt`. After bit index 7, go to PARITY if enabled, otherwise STOP.
  - **PARITY** (macro only): at `cnt==CLKS_PER_BIT-1`, sample the parity bit, go to STOP.
  - **STOP**: at `cnt==CLKS_PER_BIT-1`, sample `rx_s`.
    - If 1 and no parity error: load `data_rx`, pulse `rx_done`, go to IDLE.
    - If 1 with a parity error: pulse `parity_err`, leave `data_rx` unchanged, go to IDLE.
    - If 0: pulse `frame_err`, leave `data_rx` unchanged, go to BREAK.
  - **BREAK**: wait for `rx_s==1`, then go to IDLE. This prevents a held-low line from being read as repeated start bits.
- A frame that begins immediately after a stop bit is accepted: IDLE re-arms in the cycle after the stop sample.
- `rx_done`, `frame_err` and `parity_err` are mutually exclusive in any cycle.

## Timing
- Reset values: `data_rx`=8'h00, `rx_done`=0, `frame_err`=0, `parity_err`=0, `rx_busy`=0, FSM=IDLE, `cnt`=0.
- `rst` asserted mid-frame aborts the frame immediately. After release, the FSM stays in IDLE until it sees the next synchronised low.
- Let t0 be the cycle in which IDLE sees `rx_s==0`. This is 2–3 clocks after the `rx_in` falling edge because of the synchroniser.
- Sample times, relative to t0:
  - start bit: t0+HALF_BIT
  - data bit i: t0+HALF_BIT+(i+1)·CLKS_PER_BIT
  - stop bit: t0+HALF_BIT+9·CLKS_PER_BIT, or +10·CLKS_PER_BIT with parity.
- Status pulses are registered: high for exactly one cycle, starting on the edge after the stop sample.
- `data_rx` changes on the same edge that `rx_done` rises, and holds until the next valid frame.
- There is no back-pressure. A consumer that misses the `rx_done` cycle loses that byte.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The frame is 8E1: an even-parity bit follows data bit 7, and the PARITY state is compiled in.
  - Mismatch (XOR of the 8 data bits and the parity bit ≠ 0) gives a `parity_err` pulse in place of `rx_done`.
- Not defined:
  - The frame is 8N1 and the PARITY state is absent.
  - `parity_err` is tied to 0.

## Test plan
Bench: 50 MHz `clk` (20 ns period), driving `rx_in` at `CLKS_PER_BIT`=5208 clocks per bit.
- Send 0x55 (8N1) → exactly one `rx_done` pulse, `data_rx`=8'h55, `frame_err`=0, `rx_busy` low afterwards.
- Send 0x00 then 0xFF back-to-back with no idle between frames → two `rx_done` pulses, `data_rx`=8'h00 then 8'hFF; the second pulse is 10·5208 clocks after the first.
- Drive `rx_in` low for 1000 clocks, then high → no pulses, FSM back in IDLE by t0+2604, `data_rx` unchanged.
- Send 0xA5 with the stop bit low, and hold the line low 3 bit-times → single `frame_err` pulse, `data_rx` keeps its previous value, no spurious start. Then a valid 0x3C → `rx_done`, `data_rx`=8'h3C.
- Assert `rst` during data bit 4 of 0x81 → outputs return to their reset values at once. The remaining bits of that frame cause no pulse, but may cause one false start or `frame_err`. The next full 0x81 frame sent after the line has been high ≥1 bit-time → `data_rx`=8'h81.
- With `UART_RX_PARITY_EN`: 0x07 with parity 1 → `rx_done`, `data_rx`=8'h07. 0x07 with parity 0 → `parity_err` pulse, `data_rx` unchanged.
